// File: rtl/fpga_mem_pkg.sv
// Shared types for the LSU-to-FPGA-bridge request queue.
// Holds FSM/op encodings and the 72-bit queued request layout.
package fpga_mem_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 7;
  localparam int ENTRY_W = 72;

  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_WAIT = 2'b01
  } q_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } req_t;

endpackage

// File: rtl/fpga_mem_req_fifo.sv
// DEPTH x ENTRY_W request FIFO, head is read combinationally.
// Push is qualified by the pre-pop full flag.
module fpga_mem_req_fifo
  import fpga_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  req_t                   din_i,
  input  logic                   pop_i,
  output req_t                   dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = req_t'(mem_q[rd_ptr_q]);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers are AW bits wide, so wrap is the natural modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= ENTRY_W'(din_i);
  end

endmodule

// File: rtl/fpga_mem_req_queue.sv
// LSU request queue issuing one outstanding transaction to the memory bridge.
// Optional watchdog enabled by defining FPGA_MEM_REQQ_TIMEOUT_EN.
module fpga_mem_req_queue
  import fpga_mem_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lsu_wr_en,
  input  logic                   lsu_rd_en,
  input  logic [31:0]            lsu_addr,
  input  logic [31:0]            lsu_wr_data,
  input  logic [6:0]             lsu_tag,
  output logic                   lsu_full,
  output logic                   lsu_ack,
  output logic [31:0]            lsu_rd_data,
  output logic [6:0]             lsu_tag_resp,
  output logic                   mem_wr_en,
  output logic                   mem_rd_en,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wr_data,
  output logic [6:0]             mem_tag_req,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rd_data,
  input  logic [6:0]             mem_tag_resp,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   overflow,
  output logic                   timeout
);

  q_state_e state_q, state_d;
  req_t     push_req, head_req;
  logic     push, pop, fifo_full, fifo_empty;

  logic        mem_wr_en_q, mem_wr_en_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic [6:0]  mem_tag_q, mem_tag_d;
  logic        lsu_ack_q, lsu_ack_d;
  logic [31:0] lsu_rd_data_q, lsu_rd_data_d;
  logic [6:0]  lsu_tag_q, lsu_tag_d;
  logic        overflow_q, overflow_d;

  assign push = lsu_wr_en | lsu_rd_en;

  // Write wins when both strobes are high
  always_comb begin
    push_req      = '0;
    push_req.op   = lsu_wr_en ? OP_WRITE : OP_READ;
    push_req.addr = lsu_addr;
    push_req.data = lsu_wr_data;
    push_req.tag  = lsu_tag;
  end

  fpga_mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_req),
    .pop_i   (pop),
    .dout_o  (head_req),
    .count_o (q_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign lsu_full = fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= Q_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      Q_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = Q_WAIT;
        end
      end
      Q_WAIT: begin
        if (mem_ack) state_d = Q_IDLE;
      end
      default: state_d = Q_IDLE;
    endcase
  end

  always_comb begin
    mem_wr_en_d   = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_tag_d     = mem_tag_q;
    lsu_ack_d     = 1'b0;
    lsu_rd_data_d = lsu_rd_data_q;
    lsu_tag_d     = lsu_tag_q;
    overflow_d    = overflow_q | (push & fifo_full);
    if (pop) begin
      mem_wr_en_d   = (head_req.op == OP_WRITE);
      mem_rd_en_d   = (head_req.op == OP_READ);
      mem_addr_d    = head_req.addr;
      mem_wr_data_d = head_req.data;
      mem_tag_d     = head_req.tag;
    end
    if (state_q == Q_WAIT && mem_ack) begin
      lsu_ack_d     = 1'b1;
      lsu_rd_data_d = mem_rd_data;
      lsu_tag_d     = mem_tag_resp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_tag_q     <= '0;
      lsu_ack_q     <= 1'b0;
      lsu_rd_data_q <= '0;
      lsu_tag_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_tag_q     <= mem_tag_d;
      lsu_ack_q     <= lsu_ack_d;
      lsu_rd_data_q <= lsu_rd_data_d;
      lsu_tag_q     <= lsu_tag_d;
      overflow_q    <= overflow_d;
    end
  end

  assign mem_wr_en    = mem_wr_en_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_tag_req  = mem_tag_q;
  assign lsu_ack      = lsu_ack_q;
  assign lsu_rd_data  = lsu_rd_data_q;
  assign lsu_tag_resp = lsu_tag_q;
  assign overflow     = overflow_q;

`ifdef FPGA_MEM_REQQ_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Flag only; the FSM keeps waiting for the bridge
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (pop) begin
      wd_d = '0;
    end else if (state_q == Q_WAIT) begin
      wd_d = wd_q + 32'd1;
      if (wd_q == 32'(TIMEOUT_CYCLES - 1)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_mem_req_queue.sv
// Randomized bench for fpga_mem_req_queue against a transaction-level model.
// Timeout expectations follow FPGA_MEM_REQQ_TIMEOUT_EN.
module tb_fpga_mem_req_queue;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_wr_en, lsu_rd_en;
  logic [31:0] lsu_addr, lsu_wr_data;
  logic [6:0]  lsu_tag;
  logic        lsu_full, lsu_ack;
  logic [31:0] lsu_rd_data;
  logic [6:0]  lsu_tag_resp;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_wr_data;
  logic [6:0]  mem_tag_req;
  logic        mem_ack;
  logic [31:0] mem_rd_data;
  logic [6:0]  mem_tag_resp;
  logic [3:0]  q_count;
  logic        overflow, timeout;

  fpga_mem_req_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .lsu_wr_en(lsu_wr_en), .lsu_rd_en(lsu_rd_en),
    .lsu_addr(lsu_addr), .lsu_wr_data(lsu_wr_data), .lsu_tag(lsu_tag),
    .lsu_full(lsu_full), .lsu_ack(lsu_ack),
    .lsu_rd_data(lsu_rd_data), .lsu_tag_resp(lsu_tag_resp),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_tag_req(mem_tag_req), .mem_ack(mem_ack),
    .mem_rd_data(mem_rd_data), .mem_tag_resp(mem_tag_resp),
    .q_count(q_count), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          op;
    logic [31:0] a;
    logic [31:0] d;
    logic [6:0]  t;
  } ent_t;

  ent_t        mq[$];
  bit          busy, m_ovf, m_tmo;
  int          wcnt;
  bit          e_wr, e_rd, e_ack;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [6:0]  e_tag, e_rtag;
  int          n_cmp, n_bad;
  bit          br_auto, br_pend;
  int          br_dly;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    busy = 0; m_ovf = 0; m_tmo = 0; wcnt = 0;
    e_wr = 0; e_rd = 0; e_ack = 0;
    e_addr = 0; e_wdata = 0; e_tag = 0; e_rdata = 0; e_rtag = 0;
  endtask

  // One clock edge worth of queue/bridge-protocol behaviour
  task automatic model_step();
    int   sz;
    ent_t e;
    sz = mq.size();
    e_wr = 0; e_rd = 0; e_ack = 0;
    if (!busy) begin
      if (sz > 0) begin
        e = mq.pop_front();
        busy = 1; wcnt = 0;
        e_wr = e.op; e_rd = !e.op;
        e_addr = e.a; e_wdata = e.d; e_tag = e.t;
      end
    end else begin
      wcnt++;
      if (wcnt == TMO) m_tmo = 1;
      if (mem_ack) begin
        busy = 0; e_ack = 1;
        e_rdata = mem_rd_data; e_rtag = mem_tag_resp;
      end
    end
    if (lsu_wr_en || lsu_rd_en) begin
      if (sz < DEPTH) mq.push_back('{lsu_wr_en, lsu_addr, lsu_wr_data, lsu_tag});
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("lsu_full", 32'(lsu_full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wr_data", mem_wr_data, e_wdata);
    chk("mem_tag_req", 32'(mem_tag_req), 32'(e_tag));
    chk("lsu_ack", 32'(lsu_ack), 32'(e_ack));
    chk("lsu_rd_data", lsu_rd_data, e_rdata);
    chk("lsu_tag_resp", 32'(lsu_tag_resp), 32'(e_rtag));
`ifdef FPGA_MEM_REQQ_TIMEOUT_EN
    chk("timeout", 32'(timeout), 32'(m_tmo));
`else
    chk("timeout", 32'(timeout), 32'd0);
`endif
  endtask

  task automatic drv(input bit w, input bit r, input logic [31:0] a,
                     input logic [31:0] d, input logic [6:0] t,
                     input bit ack, input logic [31:0] rdd,
                     input logic [6:0] rtg);
    @(negedge clk);
    lsu_wr_en = w; lsu_rd_en = r;
    lsu_addr = a; lsu_wr_data = d; lsu_tag = t;
    mem_rd_data = rdd; mem_tag_resp = rtg;
    if (br_auto) begin
      if (br_pend) begin
        if (br_dly == 0) ack = 1;
        else begin br_dly--; ack = 0; end
      end else begin
        ack = ($urandom_range(7) == 0);
      end
    end
    mem_ack = ack;
    if (ack) br_pend = 0;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (mem_wr_en || mem_rd_en) begin
      br_pend = 1;
      br_dly  = $urandom_range(4);
    end
    lsu_wr_en = 0; lsu_rd_en = 0; mem_ack = 0;
  endtask

  task automatic idle(input bit ack);
    drv(0, 0, $urandom, $urandom, 7'($urandom), ack, $urandom, 7'($urandom));
  endtask

  task automatic drain();
    br_auto = 1;
    for (int k = 0; k < 300 && (mq.size() > 0 || busy); k++) idle(0);
    chk("drain_q", 32'(q_count), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);
    br_auto = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    int mx;
    n_cmp = 0; n_bad = 0;
    br_auto = 0; br_pend = 0; br_dly = 0;
    lsu_wr_en = 0; lsu_rd_en = 0; lsu_addr = 0; lsu_wr_data = 0;
    lsu_tag = 0; mem_ack = 0; mem_rd_data = 0; mem_tag_resp = 0;
    rst = 1;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 0;

    // single read with ack 4 cycles after the issue pulse
    drv(0, 1, 32'h100, 32'h0, 7'd5, 0, 32'h0, 7'd0);
    idle(0);
    chk("rd_issue", 32'(mem_rd_en), 32'd1);
    chk("rd_addr", mem_addr, 32'h100);
    repeat (4) idle(0);
    drv(0, 0, 32'h0, 32'h0, 7'd0, 1, 32'hCAFEF00D, 7'd5);
    chk("rd_ack", 32'(lsu_ack), 32'd1);
    chk("rd_data", lsu_rd_data, 32'hCAFEF00D);
    chk("rd_tag", 32'(lsu_tag_resp), 32'd5);
    idle(0);

    // burst of 8 writes with the bridge stalled
    mx = 0;
    for (int i = 0; i < 8; i++) begin
      drv(1, 0, 32'(i), $urandom, 7'(i), 0, $urandom, 7'($urandom));
      if (int'(q_count) > mx) mx = int'(q_count);
    end
    chk("burst_max", 32'(mx), 32'd7);
    chk("burst_ovf", 32'(overflow), 32'd0);
    drain();

    // overflow: 10 pushes, bridge silent
    for (int i = 0; i < 10; i++) begin
      drv(0, 1, 32'h200 + 32'(i), $urandom, 7'(8'h40 + i), 0, $urandom, 7'd0);
      if (i == 8) begin
        chk("full_at8", 32'(lsu_full), 32'd1);
        chk("ovf_before", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    drain();

    // both strobes: write wins
    drv(1, 1, 32'h300, 32'h12345678, 7'd9, 0, $urandom, 7'd0);
    idle(0);
    chk("both_wr", 32'(mem_wr_en), 32'd1);
    chk("both_rd", 32'(mem_rd_en), 32'd0);
    chk("both_data", mem_wr_data, 32'h12345678);
    drain();

    // random traffic with a randomly delayed bridge
    br_auto = 1;
    repeat (400)
      drv($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom,
          $urandom, 7'($urandom), 0, $urandom, 7'($urandom));
    drain();

    // async reset mid-wait with 3 entries queued
    for (int i = 0; i < 4; i++)
      drv(0, 1, 32'h500 + 32'(i), $urandom, 7'(i), 0, $urandom, 7'd0);
    chk("pre_rst_q", 32'(q_count), 32'd3);
    @(negedge clk);
    #2 rst = 1;
    #1;
    model_reset();
    br_pend = 0;
    compare_all();
    chk("rst_qcnt", 32'(q_count), 32'd0);
    @(negedge clk);
    rst = 0;
    idle(1);
    idle(0);
    chk("rst_noack", 32'(lsu_ack), 32'd0);

    // never-acked request for the watchdog
    drv(0, 1, 32'h400, 32'h0, 7'd3, 0, 32'h0, 7'd0);
    repeat (22) idle(0);
`ifdef FPGA_MEM_REQQ_TIMEOUT_EN
    chk("tmo_final", 32'(timeout), 32'd1);
`else
    chk("tmo_final", 32'(timeout), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpga_mem_req_queue.md
Name: fpga_mem_req_queue

Overview:
Request buffer between the LSU and the FPGA memory bridge. It accepts LSU read/write requests into a FIFO and issues them one at a time downstream. Each downstream request is a one-cycle enable pulse with addr/data/tag. The block waits for the bridge's mem_ack, then returns the response (read data and tag) to the LSU. This lets the LSU issue back-to-back requests while the bridge serves one outstanding transaction.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
lsu_wr_en  in  1  write request strobe
lsu_rd_en  in  1  read request strobe
lsu_addr  in  32  request address
lsu_wr_data  in  32  write data
lsu_tag  in  7  request tag
lsu_full  out  1  FIFO full; LSU must not strobe while high
lsu_ack  out  1  one-cycle response pulse
lsu_rd_data  out  32  response data
lsu_tag_resp  out  7  response tag
mem_wr_en  out  1  downstream write pulse
mem_rd_en  out  1  downstream read pulse
mem_addr  out  32  downstream address
mem_wr_data  out  32  downstream write data
mem_tag_req  out  7  downstream tag
mem_ack  in  1  downstream completion pulse
mem_rd_data  in  32  downstream read data
mem_tag_resp  in  7  downstream returned tag
q_count  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: request dropped because FIFO was full
timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset (asynchronous, rst=1): FIFO empty, state Q_IDLE. Every output is 0, including the data and tag registers, q_count, overflow and timeout. lsu_full=0.
- Push: happens on any cycle where (lsu_wr_en | lsu_rd_en) is high and the FIFO is not full.
  - Entry = {op, addr, wr_data, tag}, 72 bits.
  - op=WRITE if lsu_wr_en is high; write wins when both strobes are high. Otherwise op=READ.
- Push while full: the request is dropped, overflow is set (sticky until reset), and q_count is unchanged.
- lsu_full = (q_count == DEPTH). It is derived combinationally from registered count.
- Simultaneous push and pop:
  - When not full, both occur and q_count is unchanged.
  - When full, the push is evaluated against the pre-pop count and is rejected.
- Pointers wrap modulo DEPTH.
- State machine, all outputs registered:
  - Q_IDLE: if the FIFO is non-empty, pop the head and load mem_addr, mem_wr_data and mem_tag_req. Assert mem_wr_en or mem_rd_en (per op) for the next cycle only, then go to Q_WAIT.
  - Q_WAIT: mem_*_en is 0 and the mem_addr/data/tag outputs hold. On mem_ack:
    - capture mem_rd_data into lsu_rd_data and mem_tag_resp into lsu_tag_resp;
    - pulse lsu_ack for one cycle;
    - go to Q_IDLE.
  - Writes also produce lsu_ack. lsu_rd_data is captured for writes as well and is don't-care.
  - mem_ack in Q_IDLE is ignored.
- Latency:
  - A push in cycle N can produce mem_*_en high in cycle N+1 at the earliest.
  - mem_ack in cycle T gives lsu_ack in T+1.
  - The next issue comes no earlier than T+2, which guarantees the bridge has returned to idle.
- Exactly one downstream transaction is outstanding at any time.
- Reset mid-transaction aborts the FIFO and state immediately. The downstream bridge shares the same rst.

Optional Feature:
FPGA_MEM_REQQ_TIMEOUT_EN
- Defined:
  - A 32-bit counter clears on entry to Q_WAIT and increments each cycle while in Q_WAIT.
  - When it reaches TIMEOUT_CYCLES, timeout is set (sticky until reset). The state stays in Q_WAIT; there is no recovery or synthetic ack.
- Undefined: no counter is built and timeout is tied to 0.

Decomposition:
- Shared package fpga_mem_pkg holds:
  - state encodings Q_IDLE=2'b00, Q_WAIT=2'b01;
  - op encoding OP_READ=1'b0, OP_WRITE=1'b1;
  - entry field widths ADDR_W=32, DATA_W=32, TAG_W=7, ENTRY_W=72.
- One sub-module, fpga_mem_req_fifo: synchronous DEPTH x ENTRY_W FIFO with push/pop/count/full/empty and async active-high reset. The top level holds the FSM, output registers and watchdog.

Test Plan:
- Single read {addr=0x100, tag=5}; mem_ack 4 cycles after mem_rd_en with mem_rd_data=0xCAFEF00D, mem_tag_resp=5 -> mem_rd_en high exactly 1 cycle with mem_addr=0x100; lsu_ack 1 cycle after mem_ack with lsu_rd_data=0xCAFEF00D, lsu_tag_resp=5.
- Burst: 8 back-to-back writes (DEPTH=8, addr 0..7, tags 0..7) with the bridge stalled -> q_count reaches 7 after the first pop; all 8 issued in order, each only after the prior lsu_ack; no overflow.
- Overflow: hold mem_ack low and push 10 requests -> lsu_full=1 once the FIFO holds 8 entries; overflow set exactly on the first rejected push; the 10th request never appears downstream.
- Both strobes high with wr_data=0x12345678 -> mem_wr_en pulses, mem_rd_en stays 0, mem_wr_data=0x12345678.
- Async reset asserted mid-Q_WAIT with 3 queued -> all outputs 0 immediately, without waiting for a clock edge; q_count=0; no lsu_ack after reset release even if mem_ack pulses.
- With FPGA_MEM_REQQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: never ack -> timeout rises at the 16th Q_WAIT cycle and stays high; without the macro, timeout stays 0.
